// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory between the fetch and data ports. Data has priority, and a
// fetch starvation guard applies. Transactions that hang are aborted and reported as errors.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT_CYC  = 15
) (
  input  logic                clk,
  input  logic                reset,
  // Instruction fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  // Data access port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  // Memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  // Status
  output logic                busy,
  output logic                grant_d
);

  localparam int unsigned BeW = DATA_W / 8;
  localparam int unsigned SW  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] StreakMax = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TmoLast   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e              state_q;
  logic [SW-1:0]       streak_q;
  logic [TW-1:0]       tmo_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [BeW-1:0]      mem_be_q;
  logic                if_ack_q, d_ack_q, if_err_q, d_err_q;
  logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;
  logic                busy_q, grant_d_q;

  logic                pick_d;
  logic                tmo_hit;
  logic [DATA_W-1:0]   resp_rdata;

  // Data wins a tie unless fetch has already lost STARVE_LIMIT times in a row.
  assign pick_d     = d_req && (!if_req || (streak_q != StreakMax));
  assign tmo_hit    = (tmo_q == TmoLast);
  assign resp_rdata = (mem_ack && !mem_we_q) ? mem_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      streak_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
      grant_d_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (if_req || d_req) begin
            state_q   <= StBusy;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
            tmo_q     <= '0;
            grant_d_q <= pick_d;
            if (pick_d) begin
              mem_we_q    <= d_we;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              mem_be_q    <= d_be;
              if (!if_req) begin
                streak_q <= '0;
              end else if (streak_q != StreakMax) begin
                streak_q <= streak_q + SW'(1);
              end
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
              mem_be_q    <= '0;
              streak_q    <= '0;
            end
          end
        end
        StBusy: begin
          if (mem_ack || tmo_hit) begin
            state_q   <= StResp;
            mem_req_q <= 1'b0;
            if (grant_d_q) begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= resp_rdata;
              d_err_q   <= !mem_ack;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= resp_rdata;
              if_err_q   <= !mem_ack;
            end
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        StResp: begin
          state_q    <= StIdle;
          busy_q     <= 1'b0;
          if_ack_q   <= 1'b0;
          d_ack_q    <= 1'b0;
          if_err_q   <= 1'b0;
          d_err_q    <= 1'b0;
          if_rdata_q <= '0;
          d_rdata_q  <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign busy      = busy_q;
  assign grant_d   = grant_d_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-port expected responses are queued when requests are
// issued and popped as acks appear; a behavioural memory answers with a programmable latency.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SL = 4;
  localparam int unsigned TC = 15;

  logic          clk, reset;
  logic          if_req, if_ack, if_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_ack, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [3:0]    d_be;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_be;
  logic          busy, grant_d;

  int n_checks = 0;
  int n_errors = 0;
  int mem_lat  = 1;
  bit force_ack = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_if_q[$];
  exp_t exp_d_q[$];
  bit   own_log[$];

  mem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .STARVE_LIMIT(SL),
    .TIMEOUT_CYC (TC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .if_err   (if_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .grant_d  (grant_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Memory: acks in the mem_lat-th cycle of mem_req (0 = never); force_ack injects a stray ack.
  initial begin
    int cnt;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = force_ack;
      if (force_ack) mem_rdata = 32'hBAD0_BAD0;
      if (mem_req && mem_lat != 0) begin
        cnt++;
        if (cnt == mem_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_model(mem_addr);
          cnt       = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic wait_ack(input bit is_d);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (is_d ? d_ack : if_ack) break;
    end
    check_eq(is_d ? "d_ack_seen" : "if_ack_seen", 32'(is_d ? d_ack : if_ack), 32'(1));
  endtask

  task automatic fetch_req(input logic [31:0] a, input logic err);
    exp_t e;
    e.rdata = err ? 32'h0 : mem_model(a);
    e.err   = err;
    exp_if_q.push_back(e);
    if_addr = a;
    if_req  = 1'b1;
    wait_ack(1'b0);
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  task automatic data_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic err);
    exp_t e;
    e.rdata = (we || err) ? 32'h0 : mem_model(a);
    e.err   = err;
    exp_d_q.push_back(e);
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_be    = be;
    d_req   = 1'b1;
    wait_ack(1'b1);
    @(posedge clk);
    #1;
    d_req = 1'b0;
  endtask

  task automatic check_owner_seq(input bit exp[$]);
    check_eq("owner_count", 32'(own_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < own_log.size(); i++) begin
      check_eq($sformatf("owner[%0d]", i), 32'(own_log[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    bit seq[$];
    reset   = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_be    = '0;

    // Response monitor: scoreboard pops and ownership log.
    fork
      begin
        exp_t e;
        forever begin
          @(negedge clk);
          if (!reset && (if_ack || d_ack)) begin
            check_eq("ack_exclusive", 32'(if_ack & d_ack), 32'(0));
            check_eq("grant_matches_ack", 32'(grant_d), 32'(d_ack));
            own_log.push_back(d_ack);
            if (if_ack) begin
              check_eq("if_expected", 32'(exp_if_q.size() != 0), 32'(1));
              if (exp_if_q.size() != 0) begin
                e = exp_if_q.pop_front();
                check_eq("if_rdata", if_rdata, e.rdata);
                check_eq("if_err", 32'(if_err), 32'(e.err));
              end
            end
            if (d_ack) begin
              check_eq("d_expected", 32'(exp_d_q.size() != 0), 32'(1));
              if (exp_d_q.size() != 0) begin
                e = exp_d_q.pop_front();
                check_eq("d_rdata", d_rdata, e.rdata);
                check_eq("d_err", 32'(d_err), 32'(e.err));
              end
            end
          end
        end
      end
    join_none

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_mem_req", 32'(mem_req), 32'(0));
    check_eq("rst_mem_we", 32'(mem_we), 32'(0));
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    check_eq("rst_mem_be", 32'(mem_be), 32'(0));
    check_eq("rst_acks", 32'({if_ack, d_ack, if_err, d_err}), 32'(0));
    check_eq("rst_if_rdata", if_rdata, 32'h0);
    check_eq("rst_d_rdata", d_rdata, 32'h0);
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_grant_d", 32'(grant_d), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fetch only, zero-wait memory
    begin
      exp_t e;
      e.rdata = 32'h0050_0093;
      e.err   = 1'b0;
      exp_if_q.push_back(e);
      if_addr = 32'h100;
      if_req  = 1'b1;
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        check_eq($sformatf("fetch_mem_req_c%0d", j), 32'(mem_req), 32'(j == 1));
        check_eq($sformatf("fetch_if_ack_c%0d", j), 32'(if_ack), 32'(j == 2));
        check_eq($sformatf("fetch_d_ack_c%0d", j), 32'(d_ack), 32'(0));
        if (j == 1) begin
          check_eq("fetch_mem_addr", mem_addr, 32'h100);
          check_eq("fetch_mem_we", 32'(mem_we), 32'(0));
          check_eq("fetch_grant", 32'(grant_d), 32'(0));
        end
      end
      @(posedge clk);
      #1;
      if_req = 1'b0;
    end

    // Simultaneous requests: store wins, then fetch
    own_log.delete();
    fork
      fetch_req(32'h104, 1'b0);
      data_req(1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF, 1'b0);
      begin
        repeat (2) @(negedge clk);
        check_eq("st_grant_d", 32'(grant_d), 32'(1));
        check_eq("st_mem_we", 32'(mem_we), 32'(1));
        check_eq("st_mem_addr", mem_addr, 32'h200);
        check_eq("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check_eq("st_mem_be", 32'(mem_be), 32'hF);
      end
    join
    seq = '{1'b1, 1'b0};
    check_owner_seq(seq);

    // 3-cycle memory load: ack in cycle 4, busy cycles 1..4
    mem_lat = 3;
    begin
      exp_t e;
      e.rdata = mem_model(32'h3000);
      e.err   = 1'b0;
      exp_d_q.push_back(e);
      d_we   = 1'b0;
      d_addr = 32'h3000;
      d_req  = 1'b1;
      for (int j = 0; j < 6; j++) begin
        @(negedge clk);
        check_eq($sformatf("lat_busy_c%0d", j), 32'(busy), 32'(j >= 1 && j <= 4));
        check_eq($sformatf("lat_mem_req_c%0d", j), 32'(mem_req), 32'(j >= 1 && j <= 3));
        check_eq($sformatf("lat_d_ack_c%0d", j), 32'(d_ack), 32'(j == 4));
        if (j == 4) begin
          @(posedge clk);
          #1;
          d_req = 1'b0;
        end
      end
    end

    // Starvation guard: D x4, F, D x4, F, D
    mem_lat = 1;
    own_log.delete();
    fork
      for (int i = 0; i < 9; i++) data_req(1'b0, 32'h1000 + 32'(4 * i), 32'h0, 4'h0, 1'b0);
      begin
        fetch_req(32'h2000, 1'b0);
        fetch_req(32'h2004, 1'b0);
      end
    join
    seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    check_owner_seq(seq);

    // Timeout: memory never answers; late ack in IDLE must be ignored
    mem_lat = 0;
    begin
      exp_t e;
      e.rdata = 32'h0;
      e.err   = 1'b1;
      exp_d_q.push_back(e);
      d_we   = 1'b0;
      d_addr = 32'h3100;
      d_req  = 1'b1;
      for (int j = 0; j < 17; j++) begin
        @(negedge clk);
        if (j == 15 || j == 16) begin
          check_eq($sformatf("tmo_mem_req_c%0d", j), 32'(mem_req), 32'(j == 15));
          check_eq($sformatf("tmo_d_ack_c%0d", j), 32'(d_ack), 32'(j == 16));
          check_eq($sformatf("tmo_busy_c%0d", j), 32'(busy), 32'(1));
        end
      end
      force_ack = 1'b1;
      @(posedge clk);
      #1;
      d_req = 1'b0;
      @(negedge clk);
      force_ack = 1'b0;
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        check_eq($sformatf("late_busy_%0d", j), 32'(busy), 32'(0));
        check_eq($sformatf("late_mem_req_%0d", j), 32'(mem_req), 32'(0));
        check_eq($sformatf("late_d_ack_%0d", j), 32'(d_ack), 32'(0));
      end
    end

    // Reset mid-BUSY, then re-arbitration from a cleared streak
    @(posedge clk);
    #1;
    if_addr = 32'h400;
    d_we    = 1'b0;
    d_addr  = 32'h500;
    if_req  = 1'b1;
    d_req   = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rmid_busy_before", 32'(busy), 32'(1));
    check_eq("rmid_mem_req_before", 32'(mem_req), 32'(1));
    #1;
    reset = 1'b1;
    #1;
    check_eq("rmid_mem_req", 32'(mem_req), 32'(0));
    check_eq("rmid_busy", 32'(busy), 32'(0));
    check_eq("rmid_acks", 32'({if_ack, d_ack}), 32'(0));
    mem_lat = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rmid_hold_mem_req", 32'(mem_req), 32'(0));
    reset = 1'b0;
    own_log.delete();
    fork
      for (int i = 0; i < 5; i++) data_req(1'b0, 32'h500 + 32'(4 * i), 32'h0, 4'h0, 1'b0);
      fetch_req(32'h400, 1'b0);
    join
    seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    check_owner_seq(seq);

    check_eq("sb_if_drained", 32'(exp_if_q.size()), 32'(0));
    check_eq("sb_d_drained", 32'(exp_d_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
